// File: rtl/exu_dmem_resp.sv
// Data-memory responder for the execute-stage memory port. It services one word
// access at a time from a local RAM, with configurable wait states and error flags.
module exu_dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_rvalid,
    output logic        o_mem_wdone,
    output logic        o_mem_err,
    output logic        o_mem_stall
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);
    localparam logic        NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // The limit is computed in 33 bits so a RAM that ends at the top of the
    // address space does not wrap around to zero.
    function automatic logic req_error(input logic [31:0] addr,
                                       input logic        ren,
                                       input logic        wen);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = (addr < BASE_ADDR) || ({1'b0, addr} >= LIMIT);
        return misaligned | out_of_range | (ren & wen);
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ren_q, ren_d;
    logic               wen_q, wen_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               wdone_q, wdone_d;
    logic               errs_q, errs_d;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               req_s;
    logic [IDX_W-1:0]   idx_in_s;
    logic               enter_resp_s;
    logic               ram_we_s;

    assign req_s        = i_mem_ren | i_mem_wen;
    assign idx_in_s     = IDX_W'((i_mem_addr - BASE_ADDR) >> 2);
    assign enter_resp_s = (state_d == ST_RESP);
    assign ram_we_s     = enter_resp_s & wen_d & ~err_d & ~rst;
    assign o_mem_stall  = req_s & (state_q != ST_RESP);

    assign o_mem_rdata  = rdata_q;
    assign o_mem_rvalid = rvalid_q;
    assign o_mem_wdone  = wdone_q;
    assign o_mem_err    = errs_q;

    // Next-state and request capture; the _d values are what the commit uses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    idx_d   = idx_in_s;
                    wdata_d = i_mem_wdata;
                    ren_d   = i_mem_ren;
                    wen_d   = i_mem_wen;
                    err_d   = req_error(i_mem_addr, i_mem_ren, i_mem_wen);
                    if (NO_WAIT) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A dropped request is a core flush: abandon without side effects.
                if (!req_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response strobes and read data, loaded only on the edge entering RESP.
    always_comb begin
        rdata_d  = 32'd0;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;
        errs_d   = 1'b0;
        if (enter_resp_s) begin
            if (err_d) begin
                errs_d = 1'b1;
            end else if (ren_d) begin
                rvalid_d = 1'b1;
                rdata_d  = mem_q[idx_d];
            end else begin
                wdone_d = 1'b1;
            end
        end else begin
            rdata_d  = 32'd0;
            rvalid_d = 1'b0;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            errs_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            errs_q   <= errs_d;
        end
    end

    // Local data RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

endmodule

// File: tb/tb_exu_dmem_resp.sv
// Directed bench for exu_dmem_resp: four instances with WAIT_STATES 1, 0, 3 and 2
// share a clock and reset; each scenario task checks its own expectations inline.
module tb_exu_dmem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_ren    [4];
    logic        m_wen    [4];
    logic [31:0] m_addr   [4];
    logic [31:0] m_wdata  [4];
    logic [31:0] m_rdata  [4];
    logic        m_rvalid [4];
    logic        m_wdone  [4];
    logic        m_err    [4];
    logic        m_stall  [4];

    int          checks = 0;
    int          errors = 0;

    int          lat;
    logic [2:0]  stb;
    logic [2:0]  post;
    logic [31:0] rd;
    logic [31:0] prd;

    always #5 clk = ~clk;

    exu_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h8000_0000)) u_ws1 (
        .clk(clk), .rst(rst), .i_mem_ren(m_ren[0]), .i_mem_wen(m_wen[0]),
        .i_mem_addr(m_addr[0]), .i_mem_wdata(m_wdata[0]), .o_mem_rdata(m_rdata[0]),
        .o_mem_rvalid(m_rvalid[0]), .o_mem_wdone(m_wdone[0]), .o_mem_err(m_err[0]),
        .o_mem_stall(m_stall[0]));

    exu_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h8000_0000)) u_ws0 (
        .clk(clk), .rst(rst), .i_mem_ren(m_ren[1]), .i_mem_wen(m_wen[1]),
        .i_mem_addr(m_addr[1]), .i_mem_wdata(m_wdata[1]), .o_mem_rdata(m_rdata[1]),
        .o_mem_rvalid(m_rvalid[1]), .o_mem_wdone(m_wdone[1]), .o_mem_err(m_err[1]),
        .o_mem_stall(m_stall[1]));

    exu_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h8000_0000)) u_ws3 (
        .clk(clk), .rst(rst), .i_mem_ren(m_ren[2]), .i_mem_wen(m_wen[2]),
        .i_mem_addr(m_addr[2]), .i_mem_wdata(m_wdata[2]), .o_mem_rdata(m_rdata[2]),
        .o_mem_rvalid(m_rvalid[2]), .o_mem_wdone(m_wdone[2]), .o_mem_err(m_err[2]),
        .o_mem_stall(m_stall[2]));

    exu_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h8000_0000)) u_ws2 (
        .clk(clk), .rst(rst), .i_mem_ren(m_ren[3]), .i_mem_wen(m_wen[3]),
        .i_mem_addr(m_addr[3]), .i_mem_wdata(m_wdata[3]), .o_mem_rdata(m_rdata[3]),
        .o_mem_rvalid(m_rvalid[3]), .o_mem_wdone(m_wdone[3]), .o_mem_err(m_err[3]),
        .o_mem_stall(m_stall[3]));

    // Drives one request on instance d (entered and left 1 time unit after a rising
    // edge, in IDLE). Reports the number of stalled cycles, the strobes {rvalid,wdone,err}
    // and rdata in the response cycle, and the same one cycle after the response.
    // With mut set, addr/wdata are replaced by ma/mwd after the acceptance cycle.
    task automatic access(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic mut, input logic [31:0] ma, input logic [31:0] mwd,
                          output int lt, output logic [2:0] sb, output logic [31:0] rdv,
                          output logic [2:0] ps, output logic [31:0] prdv);
        m_ren[d]   = r;
        m_wen[d]   = w;
        m_addr[d]  = a;
        m_wdata[d] = wd;
        lt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!m_stall[d]) break;
            lt++;
            @(posedge clk);
            #1;
            if (mut && lt == 1) begin
                m_addr[d]  = ma;
                m_wdata[d] = mwd;
            end
        end
        sb  = {m_rvalid[d], m_wdone[d], m_err[d]};
        rdv = m_rdata[d];
        m_ren[d] = 1'b0;
        m_wen[d] = 1'b0;
        @(posedge clk);
        #1;
        ps   = {m_rvalid[d], m_wdone[d], m_err[d]};
        prdv = m_rdata[d];
    endtask

    task test_reset;
        for (int d = 0; d < 4; d++) begin
            m_ren[d]   = 1'b0;
            m_wen[d]   = 1'b0;
            m_addr[d]  = 32'h0;
            m_wdata[d] = 32'h0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if ({m_rvalid[d], m_wdone[d], m_err[d], m_stall[d]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_strobes[%0d]: got %b expected 0000", d,
                         {m_rvalid[d], m_wdone[d], m_err[d], m_stall[d]});
            end
            checks++;
            if (m_rdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata[%0d]: got %h expected 00000000", d, m_rdata[d]);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task test_ws1_write_read;
        access(0, 1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL ws1_wr_stall: got %0d expected 2", lat); end
        checks++;
        if (stb !== 3'b010) begin errors++; $display("FAIL ws1_wr_strobe: got %b expected 010", stb); end
        checks++;
        if (post !== 3'b000) begin errors++; $display("FAIL ws1_wr_clear: got %b expected 000", post); end
        access(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL ws1_rd_stall: got %0d expected 2", lat); end
        checks++;
        if (stb !== 3'b100) begin errors++; $display("FAIL ws1_rd_strobe: got %b expected 100", stb); end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws1_rd_data: got %h expected deadbeef", rd); end
        checks++;
        if ({post, prd} !== 35'h0) begin errors++; $display("FAIL ws1_rd_clear: got %b/%h expected 000/0", post, prd); end
    endtask

    task test_ws0_back_to_back;
        access(1, 1'b0, 1'b1, 32'h8000_0000, 32'h1234_5678, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 1 || stb !== 3'b010) begin errors++; $display("FAIL ws0_wr: got lat %0d strobe %b expected 1 010", lat, stb); end
        access(1, 1'b0, 1'b1, 32'h8000_0004, 32'hA5A5_0004, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        access(1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL ws0_rd_stall: got %0d expected 1", lat); end
        checks++;
        if (stb !== 3'b100 || rd !== 32'h1234_5678) begin errors++; $display("FAIL ws0_rd: got %b %h expected 100 12345678", stb, rd); end
        // Issued in the cycle right after the previous response.
        access(1, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL b2b_stall: got %0d expected 1", lat); end
        checks++;
        if (stb !== 3'b100 || rd !== 32'hA5A5_0004) begin errors++; $display("FAIL b2b_rd: got %b %h expected 100 a5a50004", stb, rd); end
    endtask

    task test_errors;
        access(0, 1'b0, 1'b1, 32'h8000_0000, 32'h0BAD_0000, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        access(0, 1'b1, 1'b0, 32'h8000_0002, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 2 || stb !== 3'b001 || rd !== 32'h0) begin
            errors++; $display("FAIL err_misaligned: got %0d %b %h expected 2 001 0", lat, stb, rd);
        end
        access(0, 1'b0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (stb !== 3'b001) begin errors++; $display("FAIL err_past_end: got %b expected 001", stb); end
        access(0, 1'b1, 1'b1, 32'h8000_0000, 32'h7777_7777, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (stb !== 3'b001 || rd !== 32'h0) begin errors++; $display("FAIL err_ren_wen: got %b %h expected 001 0", stb, rd); end
        access(0, 1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (stb !== 3'b001) begin errors++; $display("FAIL err_below_base: got %b expected 001", stb); end
        checks++;
        if (post !== 3'b000) begin errors++; $display("FAIL err_clear: got %b expected 000", post); end
        access(0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (stb !== 3'b100 || rd !== 32'h0BAD_0000) begin errors++; $display("FAIL err_no_write: got %b %h expected 100 0bad0000", stb, rd); end
    endtask

    task test_flush;
        logic [3:0] seen;
        access(2, 1'b0, 1'b1, 32'h8000_0020, 32'h1111_2222, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 4 || stb !== 3'b010) begin errors++; $display("FAIL ws3_wr: got %0d %b expected 4 010", lat, stb); end
        m_wen[2]   = 1'b1;
        m_addr[2]  = 32'h8000_0020;
        m_wdata[2] = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        checks++;
        if (m_stall[2] !== 1'b1) begin errors++; $display("FAIL flush_wait_stall: got %b expected 1", m_stall[2]); end
        m_wen[2] = 1'b0;
        seen = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            #1;
            seen = seen | {m_rvalid[2], m_wdone[2], m_err[2], m_stall[2]};
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 4'b0000) begin errors++; $display("FAIL flush_quiet: got %b expected 0000", seen); end
        access(2, 1'b1, 1'b0, 32'h8000_0020, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL flush_idle: got %0d expected 4", lat); end
        checks++;
        if (rd !== 32'h1111_2222) begin errors++; $display("FAIL flush_old_value: got %h expected 11112222", rd); end
    endtask

    task test_reset_mid_wait;
        logic [2:0] seen;
        access(3, 1'b0, 1'b1, 32'h8000_0040, 32'h5555_0000, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 3 || stb !== 3'b010) begin errors++; $display("FAIL ws2_wr: got %0d %b expected 3 010", lat, stb); end
        m_wen[3]   = 1'b1;
        m_addr[3]  = 32'h8000_0040;
        m_wdata[3] = 32'h9999_9999;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({m_rvalid[3], m_wdone[3], m_err[3]} !== 3'b000 || m_rdata[3] !== 32'h0) begin
            errors++; $display("FAIL rst_wait_outputs: got %b %h expected 000 0",
                               {m_rvalid[3], m_wdone[3], m_err[3]}, m_rdata[3]);
        end
        rst = 1'b0;
        m_wen[3] = 1'b0;
        seen = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            seen = seen | {m_rvalid[3], m_wdone[3], m_err[3]};
        end
        checks++;
        if (seen !== 3'b000) begin errors++; $display("FAIL rst_wait_quiet: got %b expected 000", seen); end
        access(3, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 3 || rd !== 32'h5555_0000) begin errors++; $display("FAIL rst_wait_no_write: got %0d %h expected 3 55550000", lat, rd); end
        access(3, 1'b0, 1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (stb !== 3'b010) begin errors++; $display("FAIL last_word_wr: got %b expected 010", stb); end
        access(3, 1'b1, 1'b0, 32'h8000_0FFC, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (stb !== 3'b100 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL last_word_rd: got %b %h expected 100 cafef00d", stb, rd); end
    endtask

    task test_attr_hold;
        access(2, 1'b0, 1'b1, 32'h8000_0034, 32'h2468_ACE0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        access(2, 1'b0, 1'b1, 32'h8000_0030, 32'h1357_9BDF, 1'b1, 32'h8000_0034, 32'hFFFF_FFFF, lat, stb, rd, post, prd);
        checks++;
        if (lat !== 4 || stb !== 3'b010) begin errors++; $display("FAIL hold_wr: got %0d %b expected 4 010", lat, stb); end
        access(2, 1'b1, 1'b0, 32'h8000_0030, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (rd !== 32'h1357_9BDF) begin errors++; $display("FAIL hold_captured: got %h expected 13579bdf", rd); end
        access(2, 1'b1, 1'b0, 32'h8000_0034, 32'h0, 1'b0, 32'h0, 32'h0, lat, stb, rd, post, prd);
        checks++;
        if (rd !== 32'h2468_ACE0) begin errors++; $display("FAIL hold_untouched: got %h expected 2468ace0", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ws1_write_read();
        test_ws0_back_to_back();
        test_errors();
        test_flush();
        test_reset_mid_wait();
        test_attr_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
